tl_buffer_ad: RTL
=================

// Module: tl_buffer_ad
// PURPOSE
//  TileLink-UL buffer stage sitting directly upstream of the FIFO fixer on the 31-bit-address / 64-bit-data crossbar port.
//  Registers the A channel (toward the fixer) and the D channel (back toward the master) in independent circular queues.
//  This breaks every combinational ready/valid/bits path across the stage. Fields pass unmodified; no reordering, no merging.
// PARAMETERS
//  A_DEPTH  2  A-channel queue entries; legal 1..8; 1 = half throughput
//  D_DEPTH  2  D-channel queue entries; legal 1..8; 1 = half throughput
// PORTS
//  clock                  in   1   sole clock; all state on rising edge
//  reset                  in   1   asynchronous, active-low reset (0 = in reset)
//  auto_in_a_valid        in   1   master A request valid
//  auto_in_a_ready        out  1   queue A can accept
//  auto_in_a_bits_*       in   3/3/4/3/31/8/64/1   opcode/param/size/source/address/mask/data/corrupt
//  auto_out_a_valid       out  1   head of queue A valid (to fixer)
//  auto_out_a_ready       in   1   fixer accepts A
//  auto_out_a_bits_*      out  3/3/4/3/31/8/64/1   same fields as auto_in_a_bits_*
//  auto_out_d_valid       in   1   fixer D response valid
//  auto_out_d_ready       out  1   queue D can accept
//  auto_out_d_bits_*      in   3/2/4/3/1/1/64/1    opcode/param/size/source/sink/denied/data/corrupt
//  auto_in_d_valid        out  1   head of queue D valid (to master)
//  auto_in_d_ready        in   1   master accepts D
//  auto_in_d_bits_*       out  3/2/4/3/1/1/64/1    same fields as auto_out_d_bits_*
// BEHAVIOUR
//  Each channel is an identical queue Q of DEPTH entries.
//  Q state: wr_ptr, rd_ptr (clog2(DEPTH) bits, min 1), count (0..DEPTH), entry array.
//  Reset (reset==0, async): ptrs=0, count=0, entries=0.
//   - both *_valid outputs = 0
//   - both *_ready outputs forced 0 while reset held
//   - readies rise combinationally on deassert
//  Enqueue fires when in_valid && in_ready: entry[wr_ptr] <= bits; wr_ptr++.
//  Dequeue fires when out_valid && out_ready: rd_ptr++.
//  Pointer wrap: ptr == DEPTH-1 wraps to 0. Holds for non-power-of-2 DEPTH.
//  count: +1 on enq-only, -1 on deq-only, unchanged on both or neither.
//  in_ready  = (count != DEPTH), registered-state only.
//  out_valid = (count != 0), registered-state only.
//  No combinational path input->output on any signal.
//  Latency: a beat enqueued at cycle N is presented at the output at N+1 earliest.
//  Full + dequeue in the same cycle: in_ready stays 0 that cycle (no pipe-through).
//   - New beat accepted the following cycle.
//  Empty + enqueue: no flow-through; out_valid rises next cycle.
//  Simultaneous enq/deq when 0<count<DEPTH: both fire; count unchanged.
//  out_bits = entry[rd_ptr], always driven.
//   - Meaningful only while out_valid; stale data otherwise is legal.
//  Held output stable: while out_valid && !out_ready, out_bits and out_valid must not change.
//  Multi-beat bursts (size>3, data opcodes) are buffered beat-by-beat, order preserved.
//  A and D queues are fully independent; no cross-channel flow control.
//  Reset mid-burst: all in-flight beats are discarded.
//   - Upstream/downstream are reset in the same domain; no recovery required.
//  Assertions (sim only): no enq when full, no deq when empty, count <= DEPTH.
// TESTING
//  1 Reset: hold reset=0 with in_a_valid=1 -> a_ready=0, out_a_valid=0, in_d_valid=0.
//    Release -> a_ready=1 same cycle.
//  2 Single A beat: source=5, addr=0x4000_0000, opcode=4 (Get) at cycle N -> out_a_valid=1 at N+1.
//    Fields bit-identical; out_a_ready=1 drains it; count back to 0.
//  3 Fill, DEPTH=2: out_a_ready=0, push 3 PutFull beats -> a_ready=0 after 2nd.
//    3rd held; raise out_a_ready -> beats emerge in order 1,2,3.
//    a_ready re-asserts the cycle after the first deq.
//  4 Back-pressure stability: out_d_ready-side stalls 5 cycles with in_d_ready=0 ->
//    auto_in_d_bits (data=0xDEAD_BEEF_0123_4567, denied=1) constant, valid constant.
//  5 Streaming: both sides valid/ready=1 for 64 cycles on A and D concurrently ->
//    64 beats each, 1 beat/cycle, no loss/dup, pointer wrap exercised.
//    Repeat with DEPTH=1 -> 1 beat per 2 cycles.
//  6 Reset mid-burst: 2 of 8 beats queued, assert reset -> both queues empty.
//    First post-reset beat is the first beat sent after release.

Source files
------------

// File: rtl/tl_buffer_ad.sv
// tl_buffer_ad: TileLink-UL buffer stage registering the A and D channels in
// independent circular queues so no ready/valid/bits path crosses the stage.

module tl_buffer_ad_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_bits,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_bits
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_enq, w_deq;
    logic [PW-1:0] w_wr_nxt, w_rd_nxt;

    // Readies drop while reset is held and rise as soon as it releases.
    assign o_ready  = reset && (r_count != CW'(DEPTH));
    assign o_valid  = (r_count != '0);
    assign o_bits   = r_mem[r_rd];
    assign w_enq    = i_valid && o_ready;
    assign w_deq    = o_valid && i_ready;
    assign w_wr_nxt = (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
    assign w_rd_nxt = (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr] <= i_bits;
                r_wr        <= w_wr_nxt;
            end
            if (w_deq) r_rd <= w_rd_nxt;
            if (w_enq && !w_deq) r_count <= r_count + CW'(1);
            else if (w_deq && !w_enq) r_count <= r_count - CW'(1);
        end
    end

    a_no_enq_full:  assert property (@(posedge clock) disable iff (!reset) !(w_enq && r_count == CW'(DEPTH)));
    a_no_deq_empty: assert property (@(posedge clock) disable iff (!reset) !(w_deq && r_count == '0));
    a_count_range:  assert property (@(posedge clock) disable iff (!reset) r_count <= CW'(DEPTH));
endmodule

module tl_buffer_ad #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [2:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_out_a_valid,
    input  logic        auto_out_a_ready,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [3:0]  auto_out_a_bits_size,
    output logic [2:0]  auto_out_a_bits_source,
    output logic [30:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,
    input  logic        auto_out_d_valid,
    output logic        auto_out_d_ready,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [1:0]  auto_out_d_bits_param,
    input  logic [3:0]  auto_out_d_bits_size,
    input  logic [2:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_sink,
    input  logic        auto_out_d_bits_denied,
    input  logic [63:0] auto_out_d_bits_data,
    input  logic        auto_out_d_bits_corrupt,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [2:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    logic [116:0] w_a_in, w_a_out;
    logic [78:0]  w_d_in, w_d_out;

    assign w_a_in = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                     auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                     auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_out;
    assign w_d_in = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                     auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                     auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = w_d_out;

    tl_buffer_ad_queue #(.DEPTH(A_DEPTH), .W(117)) u_a_q (
        .clock   (clock),
        .reset   (reset),
        .i_valid (auto_in_a_valid),
        .o_ready (auto_in_a_ready),
        .i_bits  (w_a_in),
        .o_valid (auto_out_a_valid),
        .i_ready (auto_out_a_ready),
        .o_bits  (w_a_out)
    );

    tl_buffer_ad_queue #(.DEPTH(D_DEPTH), .W(79)) u_d_q (
        .clock   (clock),
        .reset   (reset),
        .i_valid (auto_out_d_valid),
        .o_ready (auto_out_d_ready),
        .i_bits  (w_d_in),
        .o_valid (auto_in_d_valid),
        .i_ready (auto_in_d_ready),
        .o_bits  (w_d_out)
    );
endmodule
